// File: rtl/reg_writeback_queue.sv
// In-order write-back queue feeding the register file write port.
// Accepts up to two results per cycle (load first, then ALU), retires one per cycle, flags RAW hazards.
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      MemValid,
    input  logic [ADDR_W-1:0]         MemReg,
    input  logic [DATA_W-1:0]         MemData,
    input  logic                      AluValid,
    input  logic [ADDR_W-1:0]         AluReg,
    input  logic [DATA_W-1:0]         AluData,
    input  logic [ADDR_W-1:0]         ReadReg1,
    input  logic [ADDR_W-1:0]         ReadReg2,
    output logic                      Stall,
    output logic                      Hazard1,
    output logic                      Hazard2,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         WriteReg,
    output logic [DATA_W-1:0]         WriteData,
    output logic [$clog2(DEPTH):0]    Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACTIVE,
        ST_STALLED
    } state_t;

    logic [ADDR_W-1:0] reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CNT_W-1:0]  push_cnt;
    logic [PTR_W-1:0]  alu_slot;
    logic              mem_push, alu_push, pop, stall;

    logic              regwrite_reg;
    logic [ADDR_W-1:0] writereg_reg;
    logic [DATA_W-1:0] writedata_reg;

    state_t            state_reg, state_next;

    logic [DEPTH-1:0]  ent_valid, hit1, hit2;

    // Count never passes DEPTH-1: pushes are only taken at DEPTH-2 or below, and a
    // non-empty queue always pops on the same edge.
    assign stall    = count_reg >= CNT_W'(DEPTH - 1);
    assign mem_push = MemValid && (MemReg != '0) && !stall;
    assign alu_push = AluValid && (AluReg != '0) && !stall;
    assign pop      = count_reg != '0;
    assign push_cnt = CNT_W'(mem_push) + CNT_W'(alu_push);

    assign count_next  = count_reg + push_cnt - CNT_W'(pop);
    assign alu_slot    = mem_push ? (wr_ptr_reg + PTR_W'(1)) : wr_ptr_reg;
    assign wr_ptr_next = wr_ptr_reg + PTR_W'(push_cnt);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (mem_push) begin
                reg_mem[wr_ptr_reg]  <= MemReg;
                data_mem[wr_ptr_reg] <= MemData;
            end
            if (alu_push) begin
                reg_mem[alu_slot]  <= AluReg;
                data_mem[alu_slot] <= AluData;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            regwrite_reg  <= 1'b0;
            writereg_reg  <= '0;
            writedata_reg <= '0;
        end else if (pop) begin
            regwrite_reg  <= 1'b1;
            writereg_reg  <= reg_mem[rd_ptr_reg];
            writedata_reg <= data_mem[rd_ptr_reg];
        end else begin
            regwrite_reg  <= 1'b0;
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [PTR_W-1:0] offset;
            assign offset        = PTR_W'(gi) - rd_ptr_reg;
            assign ent_valid[gi] = CNT_W'(offset) < count_reg;
            assign hit1[gi]      = ent_valid[gi] && (reg_mem[gi] == ReadReg1);
            assign hit2[gi]      = ent_valid[gi] && (reg_mem[gi] == ReadReg2);
        end
    endgenerate

    assign Hazard1 = (ReadReg1 != '0) &&
                     ((|hit1) || (regwrite_reg && (writereg_reg == ReadReg1)));
    assign Hazard2 = (ReadReg2 != '0) &&
                     ((|hit2) || (regwrite_reg && (writereg_reg == ReadReg2)));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (push_cnt != '0) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (count_next == '0) begin
                    state_next = ST_EMPTY;
                end else if (count_next >= CNT_W'(DEPTH - 1)) begin
                    state_next = ST_STALLED;
                end
            end
            ST_STALLED: begin
                if (count_next < CNT_W'(DEPTH - 1)) begin
                    state_next = ST_ACTIVE;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    assign Stall     = stall;
    assign RegWrite  = regwrite_reg;
    assign WriteReg  = writereg_reg;
    assign WriteData = writedata_reg;
    assign Count     = count_reg;

endmodule
